// File: rtl/spi_rom_reader_pkg.sv
// Shared constants and state encoding for the SPI flash READ sequencer.
package spi_rom_reader_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         SPI_ADDR_W   = 24;
  localparam int         SPI_LEN_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_FIN
  } state_e;

endpackage

// File: rtl/spi_rom_reader_rx.sv
// Receive side: assembles MISO bits into bytes and holds each one for a
// valid/ready handshake with the downstream pixel path.
module spi_rom_reader_rx
  import spi_rom_reader_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       sample_i,
  input  logic       lastBit_i,
  input  logic       miso_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       stall_o
);

  logic [6:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  // A load on the handshake edge keeps valid high so no byte is dropped.
  always_comb begin
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (sample_i) begin
      if (lastBit_i) begin
        data_d  = {shift_q, miso_i};
        valid_d = 1'b1;
      end else begin
        shift_d = {shift_q[5:0], miso_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign stall_o = valid_q && !ready_i;

endmodule

// File: rtl/spi_rom_reader.sv
// SPI flash READ sequencer: sends CMD+ADDR, streams len bytes from MISO to a
// valid/ready consumer, with SCLK at clk/2 that pauses under backpressure.
module spi_rom_reader
  import spi_rom_reader_pkg::*;
#(
  parameter logic [7:0] CMD    = SPI_CMD_READ,
  parameter int         ADDR_W = SPI_ADDR_W,
  parameter int         LEN_W  = SPI_LEN_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              spi_cs_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
);

  localparam int CNT_W = LEN_W + 3;
  localparam int TX_W  = 8 + ADDR_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TX_W-1:0]  txSr_q, txSr_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rxSample, rxLastBit, rxStall, lastDataBit;
  logic [CNT_W-1:0] dataBitsM1;

  assign dataBitsM1  = {len_q, 3'b000} - CNT_W'(1);
  assign lastDataBit = (bitCnt_q == dataBitsM1);
  assign rxLastBit   = (bitCnt_q[2:0] == 3'd7);

  // In CMD/ADDR, cs low marks the setup cycle that raises cs and presents bit 0.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    len_d    = len_q;
    txSr_d   = txSr_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rxSample = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d    = len_i;
          txSr_d   = {CMD, addr_i};
          bitCnt_d = '0;
          busy_d   = 1'b1;
          state_d  = (len_i == '0) ? ST_FIN : ST_CMD;
        end
      end
      ST_CMD, ST_ADDR: begin
        if (!cs_q) begin
          cs_d   = 1'b1;
          mosi_d = txSr_q[TX_W-1];
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d   = 1'b0;
          mosi_d   = txSr_q[TX_W-2];
          txSr_d   = txSr_q << 1;
          bitCnt_d = bitCnt_q + CNT_W'(1);
          if (state_q == ST_CMD && bitCnt_q == CNT_W'(7)) begin
            state_d  = ST_ADDR;
            bitCnt_d = '0;
          end else if (state_q == ST_ADDR && bitCnt_q == CNT_W'(ADDR_W - 1)) begin
            state_d  = ST_DATA;
            bitCnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (!sclk_q) begin
          if (!(rxLastBit && rxStall)) begin
            sclk_d   = 1'b1;
            rxSample = 1'b1;
          end
        end else begin
          sclk_d   = 1'b0;
          bitCnt_d = bitCnt_q + CNT_W'(1);
          if (lastDataBit) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        cs_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      len_q    <= '0;
      txSr_q   <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      len_q    <= len_d;
      txSr_q   <= txSr_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  spi_rom_reader_rx u_rx (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .sample_i  (rxSample),
    .lastBit_i (rxLastBit),
    .miso_i    (spi_miso_i),
    .ready_i   (out_ready_i),
    .data_o    (out_data_o),
    .valid_o   (out_valid_o),
    .stall_o   (rxStall)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign spi_cs_o   = cs_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;

endmodule
